// File: rtl/log2_credit_buffer.sv
// rtl/log2_credit_buffer.sv - credit-reserving result buffer for a fixed-latency log2 pipeline
//
// Admits an operand only when a result FIFO slot is reserved for it, because the
// external log2 pipeline cannot stall. Results return on ret_* and are presented
// on a show-ahead ready/valid master port in issue order.
//
// Optional feature macro: LOG2_BUF_STATS_EN (issue/stall counters, sticky err).
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_a       operand slave port
//   issue_valid/issue_a       combinational issue to the log2 pipeline
//   ret_valid/ret_c           result return from the log2 pipeline
//   m_valid/m_ready/m_data    result master port (FIFO head)
//   err                       sticky orphan-return flag (0 without stats)

module log2_credit_buffer #(
    parameter int BITS  = 16,
    parameter int DEPTH = 8,
    parameter int DRAIN = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_a,
    output logic            issue_valid,
    output logic [BITS-1:0] issue_a,
    input  logic            ret_valid,
    input  logic [BITS-1:0] ret_c,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [BITS-1:0] m_data,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic {ST_DRAIN, ST_RUN} state_t;

    state_t          state_q;
    logic [DW-1:0]   drain_q;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [BITS-1:0] mem_q [DEPTH];

    logic          run;
    logic [CW:0]   reserved;
    logic          issue;
    logic          ret_ok;
    logic          pop;

    assign run = (state_q == ST_RUN);

    // Every admitted operand owns a slot from issue until it is popped, so the
    // FIFO can never overflow on return. Built only from registers: no path
    // from m_ready to s_ready.
    assign reserved = {1'b0, count_q} + {1'b0, inflight_q};
    assign s_ready  = run & (reserved < (CW+1)'(DEPTH));

    assign issue       = s_valid & s_ready;
    assign issue_valid = issue;
    assign issue_a     = s_a;

    // Returns during DRAIN are stale results from before reset and are dropped.
    assign ret_ok  = ret_valid & run & (inflight_q != '0);
    assign m_valid = (count_q != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? mem_q[rd_q] : '0;

    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        if (ret_ok) wr_d = wr_q + AW'(1);
        if (pop)    rd_d = rd_q + AW'(1);
        count_d    = count_q + CW'(ret_ok) - CW'(pop);
        inflight_d = inflight_q + CW'(issue) - CW'(ret_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    if (drain_q == DW'(DRAIN - 1)) state_q <= ST_RUN;
                    else                           drain_q <= drain_q + DW'(1);
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (ret_ok) mem_q[wr_q] <= ret_c;
    end

`ifdef LOG2_BUF_STATS_EN
    logic        ret_orphan;
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        err_q;

    assign ret_orphan = ret_valid & run & (inflight_q == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (issue && (issue_cnt_q != '1))
                issue_cnt_q <= issue_cnt_q + 32'd1;
            if (run && s_valid && !s_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ret_orphan)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
